// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage with pipelined imem requests, a response FIFO feeding decode,
// and redirect handling that flushes the FIFO and discards stale in-flight responses.
module core_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [31:0] pc_new,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [31:0] d_ir
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;

  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
  logic [PW-1:0] p_rd_q, p_rd_d, p_wr_q, p_wr_d;
  logic [31:0]   f_pc_q [FIFO_DEPTH];
  logic [31:0]   f_ir_q [FIFO_DEPTH];
  logic [31:0]   p_pc_q [MAX_OUTST];
  logic          accept, push, pop;

  function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] p_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign imem_addr = fetch_pc_q;
  assign d_valid   = count_q != '0;
  assign d_pc      = f_pc_q[f_rd_q];
  assign d_ir      = f_ir_q[f_rd_q];

  // Credits count every live response as already occupying a FIFO slot, so a push can never overflow.
  always_comb begin
    imem_req_valid = run_q && !pc_load && (outst_q < OW'(MAX_OUTST)) &&
                     (32'(outst_q) - 32'(discard_q) + 32'(count_q) < 32'(FIFO_DEPTH));
    accept     = imem_req_valid && imem_req_ready;
    push       = imem_rsp_valid && !pc_load && discard_q == '0;
    pop        = d_valid && d_ready;
    fetch_pc_d = pc_load ? (pc_new & ~32'h3) : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    outst_d    = outst_q + OW'(accept) - OW'(imem_rsp_valid);
    discard_d  = pc_load ? outst_d : discard_q - OW'(imem_rsp_valid && discard_q != '0);
    count_d    = pc_load ? '0 : count_q + CW'(push) - CW'(pop);
    f_rd_d     = pc_load ? '0 : pop ? f_inc(f_rd_q) : f_rd_q;
    f_wr_d     = pc_load ? '0 : push ? f_inc(f_wr_q) : f_wr_q;
    p_rd_d     = imem_rsp_valid ? p_inc(p_rd_q) : p_rd_q;
    p_wr_d     = accept ? p_inc(p_wr_q) : p_wr_q;
  end

  // The PC queue pops on every response, dropped or not, so it stays aligned across redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      f_rd_q     <= '0;
      f_wr_q     <= '0;
      p_rd_q     <= '0;
      p_wr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_pc_q[i] <= '0;
        f_ir_q[i] <= '0;
      end
      for (int i = 0; i < MAX_OUTST; i++) p_pc_q[i] <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      f_rd_q     <= f_rd_d;
      f_wr_q     <= f_wr_d;
      p_rd_q     <= p_rd_d;
      p_wr_q     <= p_wr_d;
      if (push) begin
        f_pc_q[f_wr_q] <= p_pc_q[p_rd_q];
        f_ir_q[f_wr_q] <= imem_rdata;
      end
      if (accept) p_pc_q[p_wr_q] <= fetch_pc_q;
    end
  end

  a_discard_le_outst: assert property (@(posedge clk) disable iff (!rst_n) discard_q <= outst_q);
  a_outst_le_max:     assert property (@(posedge clk) disable iff (!rst_n) outst_q <= OW'(MAX_OUTST));
  a_fifo_no_ovf:      assert property (@(posedge clk) disable iff (!rst_n)
                                       !(push && !pop && count_q == CW'(FIFO_DEPTH)));
endmodule
